// File: rtl/pending_bit_drainer.sv
// Pending-bit drainer: registers a request bitmask and issues one set-bit position per
// output handshake, lowest index first. Optional macro DRAIN_BYPASS_EN allows a new vector
// to load on the final-beat handshake, which removes the idle bubble between vectors.
module pending_bit_drainer #(
  parameter int W  = 4,
  parameter int PW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pos,
  output logic          out_last,
  output logic [PW-1:0] out_idx,
  output logic          busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  pending_q, pending_d;
  logic [PW-1:0] idx_q, idx_d;

  // Lowest set index of the pending mask; an empty mask reports position 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    out_pos = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending_q[i]) out_pos = PW'(i);
    end
  end

  assign out_last  = (pending_q != '0) && ((pending_q & (pending_q - W'(1))) == '0);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_idx   = idx_q;

`ifdef DRAIN_BYPASS_EN
  assign in_ready = !reset && ((state_q == IDLE) ||
                               ((state_q == DRAIN) && out_last && out_ready));
`else
  assign in_ready = !reset && (state_q == IDLE);
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    case (state_q)
      IDLE: begin
        // A zero vector is consumed here but produces no beat.
        if (in_valid && in_vec != '0) begin
          state_d   = DRAIN;
          pending_d = in_vec;
          idx_d     = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pending_d = pending_q & ~(W'(1) << out_pos);
          idx_d     = idx_q + PW'(1);
          if (out_last) begin
            state_d = IDLE;
            idx_d   = '0;
`ifdef DRAIN_BYPASS_EN
            if (in_valid && in_vec != '0) begin
              state_d   = DRAIN;
              pending_d = in_vec;
            end
`endif
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
        idx_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: tb/tb_pending_bit_drainer.sv
// Self-checking bench for pending_bit_drainer: directed scenarios then random traffic,
// all compared against a queue-of-positions reference model.
module tb_pending_bit_drainer;

  localparam int W  = 4;
  localparam int PW = $clog2(W);
`ifdef DRAIN_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pos;
  logic          out_last;
  logic [PW-1:0] out_idx;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // Reference model: the positions still to be issued for the current vector, in order.
  int beats_q[$];
  int beat_num = 0;

  pending_bit_drainer #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .out_last(out_last), .out_idx(out_idx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then advance model and clock.
  task automatic step(input bit rst, input bit v, input logic [W-1:0] vec, input bit rdy);
    bit exp_ready;
    bit accept;
    reset     = rst;
    in_valid  = v;
    in_vec    = vec;
    out_ready = rdy;
    #1;
    exp_ready = !rst && ((beats_q.size() == 0) ||
                         (BYPASS && beats_q.size() == 1 && rdy));
    check("in_ready",  int'(in_ready),  int'(exp_ready));
    check("out_valid", int'(out_valid), int'(beats_q.size() > 0));
    check("busy",      int'(busy),      int'(beats_q.size() > 0));
    check("out_pos",   int'(out_pos),   (beats_q.size() > 0) ? beats_q[0] : 0);
    check("out_last",  int'(out_last),  int'(beats_q.size() == 1));
    check("out_idx",   int'(out_idx),   beat_num);

    accept = v && exp_ready;
    if (rst) begin
      beats_q.delete();
      beat_num = 0;
    end else begin
      if (beats_q.size() > 0 && rdy) begin
        void'(beats_q.pop_front());
        beat_num = (beats_q.size() == 0) ? 0 : beat_num + 1;
      end
      if (accept && vec != '0) begin
        beats_q.delete();
        beat_num = 0;
        for (int i = 0; i < W; i++) begin
          if (vec[i]) beats_q.push_back(i);
        end
      end
    end
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state, including in_ready low while reset is high.
    step(1, 0, 4'b0000, 0);
    step(1, 1, 4'b1111, 1);

    // 1010 with out_ready high: positions 1 then 3.
    step(0, 1, 4'b1010, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 4'b0000, 1);

    // Zero vector is dropped without a beat.
    step(0, 1, 4'b0000, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 4'b0000, 1);

    // All ones with a three-cycle stall before draining.
    step(0, 1, 4'b1111, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 4'b0000, 1);

    // Reset in the middle of draining 0111.
    step(0, 1, 4'b0111, 1);
    step(0, 0, 4'b0000, 1);
    step(1, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);

    // Back-to-back single-bit vectors.
    step(0, 1, 4'b0001, 1);
    step(0, 1, 4'b0100, 1);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);

    // in_valid held while draining: the new vector waits for in_ready.
    step(0, 1, 4'b1100, 0);
    step(0, 1, 4'b0011, 0);
    step(0, 1, 4'b0011, 0);
    step(0, 1, 4'b0011, 1);
    step(0, 1, 4'b0011, 1);
    step(0, 1, 4'b0011, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 4'b0000, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) != 0),
           W'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
